sim_run_ctrl: RTL and testbench

//  Run controller for core-level simulation. It sequences DUT reset, counts cycles and

---
 rtl/sim_ctrl_pkg.sv | 33 +++
 rtl/sat_counter.sv | 39 +++
 rtl/sim_run_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_sim_run_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sim_ctrl_pkg
//   Shared types for the simulation run controller: the run-state enum, the
//   fault code enum and the result-code width. Imported by sim_run_ctrl.
// -----------------------------------------------------------------------------
package sim_ctrl_pkg;

  // Width of the halt/result code reported by the core.
  localparam int unsigned CODE_W = 32;

  // Run sequencing: HOLD -> RUN -> DRAIN -> DONE, or RUN -> FAULT.
  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } run_state_e;

  // Encoding of the 2-bit fault output; 3 is reserved and never produced.
  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_TIMEOUT = 2'd1,
    FLT_STALL   = 2'd2,
    FLT_RSVD    = 2'd3
  } fault_e;

  // A run has ended (successfully or not) and is waiting for restart.
  function automatic logic is_terminal(input run_state_e s);
    return (s == ST_DONE) || (s == ST_FAULT);
  endfunction

endpackage : sim_ctrl_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in   clock
//     rst   in   asynchronous active-low reset (count -> 0)
//     clr   in   synchronous clear, wins over counting
//     en    in   counter is enabled this cycle
//     inc   in   count one event (only while en)
//     cnt   out  current count, W bits, registered
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = (cnt == '1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl
//   Run controller for core-level simulation. Holds the core in reset for a
//   fixed number of cycles, then counts RUN cycles and retired instructions,
//   watches for timeouts and retire stalls, drains the pipeline after the core
//   reports a halt, and ends each run as DONE (pass/fail by halt code) or
//   FAULT (timeout/stall). All outputs are registered.
//   Ports:
//     clk           in   single clock
//     rst           in   asynchronous active-low reset
//     restart       in   pulse: start a new run from DONE/FAULT
//     halt_req      in   core reports end of test
//     halt_code     in   test result, valid with halt_req
//     retire_valid  in   one instruction retired this cycle
//     core_rst      out  synchronous active-high reset to the core
//     running       out  high in RUN
//     done          out  sticky end-of-run flag (DONE or FAULT)
//     pass          out  valid with done: DONE and result_code == PASS_CODE
//     fault         out  0 none, 1 timeout, 2 stall
//     result_code   out  halt_code latched at the halt
//     cycle_cnt     out  RUN cycles this run (saturating)
//     instret_cnt   out  retired instructions this run (saturating)
// -----------------------------------------------------------------------------
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned       RESET_CYCLES = 5,       // >= 1
  parameter int unsigned       TIMEOUT      = 100000,  // < 2**CNT_W
  parameter int unsigned       STALL_LIMIT  = 1000,    // >= 1
  parameter int unsigned       DRAIN_CYCLES = 4,       // >= 1
  parameter logic [CODE_W-1:0] PASS_CODE    = '0,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              halt_req,
  input  logic [CODE_W-1:0] halt_code,
  input  logic              retire_valid,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fault,
  output logic [CODE_W-1:0] result_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  // Terminal counts: each exit fires on the cycle the counter shows N-1, so
  // the transition happens on the Nth edge.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

  run_state_e       state;

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic in_hold;
  logic in_run;
  logic in_drain;
  logic restart_ok;
  logic hold_last;
  logic drain_last;
  logic timeout_hit;
  logic stall_hit;
  logic stall_clr;

  assign in_hold    = (state == ST_HOLD);
  assign in_run     = (state == ST_RUN);
  assign in_drain   = (state == ST_DRAIN);
  // restart is only honoured once the run has ended.
  assign restart_ok = is_terminal(state) && restart;

  assign hold_last   = (hold_cnt == HOLD_LAST);
  assign drain_last  = (drain_cnt == DRAIN_LAST);
  assign timeout_hit = (cycle_cnt == TIMEOUT_LAST);
  // A retire in this cycle resets the idle streak, so it cannot stall.
  assign stall_hit   = (stall_cnt == STALL_LAST) && !retire_valid;
  assign stall_clr   = restart_ok || (in_run && retire_valid);

  // ---------------------------------------------------------------------------
  // Counters. Every counter is cleared on an accepted restart so the next
  // run starts from zero; the async reset clears them as well. Counters keep
  // counting in the exit cycle of RUN, which is what makes a retire in the
  // halt cycle (and the final timeout cycle) visible in the totals.
  // ---------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart_ok),
    .en  (in_hold),
    .inc (1'b1),
    .cnt (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart_ok),
    .en  (in_run),
    .inc (1'b1),
    .cnt (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart_ok),
    .en  (in_run),
    .inc (retire_valid),
    .cnt (instret_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stall_clr),
    .en  (in_run),
    .inc (!retire_valid),
    .cnt (stall_cnt)
  );

  // Drain timer: retire/halt are not looked at while draining.
  sat_counter #(.W(CNT_W)) u_drain_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart_ok),
    .en  (in_drain),
    .inc (1'b1),
    .cnt (drain_cnt)
  );

  // ---------------------------------------------------------------------------
  // Run FSM with registered outputs. Outputs are updated on the same edge as
  // the state change, so they always describe the state being entered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HOLD;
      core_rst    <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fault       <= FLT_NONE;
      result_code <= '0;
    end else begin
      unique case (state)
        ST_HOLD: begin
          if (hold_last) begin
            state    <= ST_RUN;
            core_rst <= 1'b0;
            running  <= 1'b1;
          end
        end

        ST_RUN: begin
          // Exit priority: halt, then timeout, then stall.
          if (halt_req) begin
            state       <= ST_DRAIN;
            running     <= 1'b0;
            result_code <= halt_code;
          end else if (timeout_hit) begin
            state   <= ST_FAULT;
            running <= 1'b0;
            done    <= 1'b1;
            fault   <= FLT_TIMEOUT;
          end else if (stall_hit) begin
            state   <= ST_FAULT;
            running <= 1'b0;
            done    <= 1'b1;
            fault   <= FLT_STALL;
          end
        end

        ST_DRAIN: begin
          if (drain_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (result_code == PASS_CODE);
          end
        end

        ST_DONE, ST_FAULT: begin
          if (restart) begin
            state       <= ST_HOLD;
            core_rst    <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fault       <= FLT_NONE;
            result_code <= '0;
          end
        end

        // NOTE: unused encodings fall back to HOLD so a corrupted state
        // register recovers into a fresh reset sequence instead of locking up.
        default: begin
          state    <= ST_HOLD;
          core_rst <= 1'b1;
          running  <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
          fault    <= FLT_NONE;
        end
      endcase
    end
  end

endmodule : sim_run_ctrl

// File: tb/tb_sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_run_ctrl
//   Self-checking bench for sim_run_ctrl. A behavioural model (countdowns for
//   the reset hold and drain, running totals, an idle streak) predicts every
//   output each cycle; directed sequences with literal expectations pin the
//   model, then randomized traffic exercises restarts, stalls, timeouts,
//   halts and async resets.
// -----------------------------------------------------------------------------
module tb_sim_run_ctrl;

  localparam int unsigned RESET_CYCLES = 5;
  localparam int unsigned TIMEOUT      = 50;
  localparam int unsigned STALL_LIMIT  = 8;
  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned CNT_W        = 32;
  localparam logic [31:0] PASS_CODE    = 32'd0;
  localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              restart = 1'b0;
  logic              halt_req = 1'b0;
  logic [31:0]       halt_code = '0;
  logic              retire_valid = 1'b0;
  logic              core_rst;
  logic              running;
  logic              done;
  logic              pass;
  logic [1:0]        fault;
  logic [31:0]       result_code;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instret_cnt;

  always #5 clk = ~clk;

  sim_run_ctrl #(
    .RESET_CYCLES (RESET_CYCLES),
    .TIMEOUT      (TIMEOUT),
    .STALL_LIMIT  (STALL_LIMIT),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .PASS_CODE    (PASS_CODE),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .halt_req     (halt_req),
    .halt_code    (halt_code),
    .retire_valid (retire_valid),
    .core_rst     (core_rst),
    .running      (running),
    .done         (done),
    .pass         (pass),
    .fault        (fault),
    .result_code  (result_code),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The run is described by what is left to do:
  // edges of reset hold remaining, drain edges remaining, and the totals.
  // ---------------------------------------------------------------------------
  int              m_hold_left;
  int              m_drain_left;
  bit              m_run;
  bit              m_done;
  bit              m_pass;
  int              m_fault;
  logic [31:0]     m_code;
  longint unsigned m_cycles;
  longint unsigned m_instret;
  longint unsigned m_idle;

  function automatic longint unsigned bump(input longint unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 64'd1;
  endfunction

  task automatic model_clear();
    m_hold_left  = RESET_CYCLES;
    m_drain_left = 0;
    m_run        = 1'b0;
    m_done       = 1'b0;
    m_pass       = 1'b0;
    m_fault      = 0;
    m_code       = '0;
    m_cycles     = 0;
    m_instret    = 0;
    m_idle       = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_run = 1'b1;
    end else if (m_run) begin
      m_cycles = bump(m_cycles);
      if (retire_valid) begin
        m_instret = bump(m_instret);
        m_idle    = 0;
      end else begin
        m_idle = bump(m_idle);
      end
      if (halt_req) begin
        m_code       = halt_code;
        m_run        = 1'b0;
        m_drain_left = DRAIN_CYCLES;
      end else if (m_cycles == TIMEOUT) begin
        m_run   = 1'b0;
        m_done  = 1'b1;
        m_fault = 1;
      end else if (m_idle == STALL_LIMIT) begin
        m_run   = 1'b0;
        m_done  = 1'b1;
        m_fault = 2;
      end
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) begin
        m_done = 1'b1;
        m_pass = (m_code == PASS_CODE);
      end
    end else if (m_done && restart) begin
      model_clear();
    end
  end

  // Single compare process, on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("core_rst",    core_rst,    64'(m_hold_left > 0));
      check("running",     running,     64'(m_run));
      check("done",        done,        64'(m_done));
      check("pass",        pass,        64'(m_pass));
      check("fault",       fault,       64'(m_fault));
      check("result_code", result_code, 64'(m_code));
      check("cycle_cnt",   cycle_cnt,   m_cycles);
      check("instret_cnt", instret_cnt, m_instret);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change right after a falling edge, then one full
  // clock passes.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic ret, input logic halt, input logic [31:0] code,
                       input logic rs);
    retire_valid = ret;
    halt_req     = halt;
    halt_code    = code;
    restart      = rs;
    @(negedge clk);
  endtask

  task automatic wait_core_rst_low(output int edges);
    edges = 0;
    while (core_rst === 1'b1 && edges < 20) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      edges++;
    end
  endtask

  task automatic wait_done(input logic ret, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      drive(ret, 1'b0, 32'd0, 1'b0);
      edges++;
    end
  endtask

  task automatic do_restart();
    int e;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    check("restart_core_rst", core_rst, 1);
    check("restart_cycle_cnt", cycle_cnt, 0);
    check("restart_instret", instret_cnt, 0);
    check("restart_done", done, 0);
    check("restart_fault", fault, 0);
    check("restart_result", result_code, 0);
    wait_core_rst_low(e);
    check("restart_hold_edges", e, 5);
  endtask

  initial begin
    int e;
    int ret_pct;
    int halt_pm;
    int r;
    int h;
    int rs;
    logic [31:0] code;

    // 1. Reset sequencing.
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_core_rst", core_rst, 1);
    check("reset_done", done, 0);
    check("reset_running", running, 0);
    check("reset_cycle_cnt", cycle_cnt, 0);
    rst = 1'b1;
    wait_core_rst_low(e);
    check("hold_edges", e, 5);
    check("run_after_hold", running, 1);
    check("cycle_cnt_start", cycle_cnt, 0);

    // 2. Retire every cycle, halt with code 0 in RUN cycle 20.
    repeat (20) drive(1'b1, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 32'd0, 1'b0);
    check("halt_instret", instret_cnt, 21);
    check("halt_running", running, 0);
    e = 0;
    while (done !== 1'b1 && e < 10) begin
      drive(1'b1, 1'b1, 32'h7, 1'b0);
      e++;
    end
    check("drain_edges", e, 4);
    check("pass_code0", pass, 1);
    check("result_code0", result_code, 0);
    check("instret_after_drain", instret_cnt, 21);
    repeat (3) drive(1'b1, 1'b1, 32'h7, 1'b0);
    check("instret_frozen", instret_cnt, 21);
    check("done_sticky", done, 1);

    // 6a + 3. Restart from DONE, then a failing halt code.
    do_restart();
    repeat (5) drive(1'b1, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b1, 32'd3, 1'b0);
    wait_done(1'b0, e);
    check("drain_edges_code3", e, 4);
    check("pass_code3", pass, 0);
    check("fault_code3", fault, 0);
    check("result_code3", result_code, 3);
    check("instret_code3", instret_cnt, 5);

    // 4. Timeout with retires every cycle.
    do_restart();
    wait_done(1'b1, e);
    check("timeout_edges", e, 50);
    check("timeout_fault", fault, 1);
    check("timeout_cycle_cnt", cycle_cnt, 50);
    check("timeout_pass", pass, 0);

    // 5. Stall: retire stops at RUN cycle 10; restart pulses in RUN ignored.
    do_restart();
    repeat (10) drive(1'b1, 1'b0, 32'd0, 1'b0);
    e = 0;
    while (done !== 1'b1 && e < 200) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      e++;
    end
    check("stall_idle_edges", e, 8);
    check("stall_fault", fault, 2);
    check("stall_cycle_cnt", cycle_cnt, 18);
    check("stall_instret", instret_cnt, 10);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check("stall_sticky", fault, 2);

    // 5b. Halt and timeout in the same cycle: the halt wins.
    do_restart();
    repeat (49) drive(1'b1, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 32'd0, 1'b0);
    check("halt_vs_timeout_fault", fault, 0);
    check("halt_vs_timeout_done", done, 0);
    wait_done(1'b0, e);
    check("halt_vs_timeout_drain", e, 4);
    check("halt_vs_timeout_pass", pass, 1);
    check("halt_vs_timeout_cycles", cycle_cnt, 50);

    // 6b. Async reset during DRAIN.
    do_restart();
    repeat (3) drive(1'b1, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b1, 32'd5, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check("drain_result", result_code, 5);
    #2 rst = 1'b0;
    #1;
    check("abort_core_rst", core_rst, 1);
    check("abort_done", done, 0);
    check("abort_result", result_code, 0);
    check("abort_cycle_cnt", cycle_cnt, 0);
    check("abort_instret", instret_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_core_rst_low(e);
    check("abort_hold_edges", e, 5);

    // Randomized traffic, checked by the model every cycle.
    for (int ep = 0; ep < 60; ep++) begin
      case ($urandom_range(0, 3))
        0:       ret_pct = 0;
        1:       ret_pct = 40;
        2:       ret_pct = 90;
        default: ret_pct = 100;
      endcase
      halt_pm = ($urandom_range(0, 1) == 0) ? 0 : 30;
      for (int c = 0; c < 100; c++) begin
        r    = ($urandom_range(0, 99) < ret_pct) ? 1 : 0;
        h    = ($urandom_range(0, 999) < halt_pm) ? 1 : 0;
        rs   = ($urandom_range(0, 5) == 0) ? 1 : 0;
        code = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        if ($urandom_range(0, 399) == 0) begin
          #2 rst = 1'b0;
          @(negedge clk);
          #1 rst = 1'b1;
          @(negedge clk);
        end else begin
          drive(r[0], h[0], code, rs[0]);
        end
      end
    end

    chk_en = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sim_run_ctrl
